sonar_echo_ranger: RTL and testbench
====================================

Name: sonar_echo_ranger

Overview:
- Drives one ultrasonic ranger channel. It issues the SONAR_TRIGn pulse, then times the returning SONAR_ECHOn pulse in microseconds.
- Four instances sit in the motion-controller fabric, one per sonar channel. The MCU-facing register block polls them.
- Runs on the single system clock. Includes its own echo synchroniser, a microsecond prescaler, and a timeout.

Parameters:
- TICK_DIV, 50, clock cycles per 1 us tick (50 MHz clock). Must be >= 2.
- TRIG_US, 10, trigger pulse width in us.
- TIMEOUT_US, 30000, maximum wait for echo rise, and maximum echo width, in us. Must be < 65535.
- CNT_W, 16, width of the us counters and of echo_us.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a measurement.
- sonar_echo  in  1  raw echo pin, asynchronous to clk.
- sonar_trig  out  1  trigger pin to the ranger.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when a measurement ends, valid or timeout.
- timeout  out  1  status of the last measurement: 1 = no valid echo. Updated with done.
- echo_us  out  CNT_W  echo high time in us, truncated. Holds until the next done.

Behaviour:
- Reset, applied asynchronously: state=IDLE; sonar_trig=0; busy=0; done=0; timeout=0; echo_us=0; synchroniser flops=0; all counters=0.
- Echo path:
  - Two-flop synchroniser, then a third flop for edge detect.
  - rise = sync & ~prev. fall = ~sync & prev.
  - Pin-to-detect latency: 2 clk cycles plus the sampling edge.
- Tick prescaler:
  - Counts 0..TICK_DIV-1. tick is high when count = TICK_DIV-1, then the count wraps to 0.
  - The prescaler and the us counter both clear on every state entry.
- States:
  - IDLE: if start=1, go to TRIG. start in any other state is ignored; no queueing.
  - TRIG:
    - sonar_trig=1 for exactly TRIG_US*TICK_DIV cycles, i.e. the cycle after start through TRIG_US ticks.
    - Then sonar_trig=0, go to WAIT_RISE.
  - WAIT_RISE:
    - On rise, go to MEASURE.
    - If the us counter reaches TIMEOUT_US first, go to FINISH with a timeout result.
    - An echo already high on entry is not a rise; the block waits for a real low->high edge.
  - MEASURE:
    - The us counter increments on each tick.
    - On fall: echo_us <= us counter, timeout <= 0, go to FINISH.
    - If the counter reaches TIMEOUT_US before fall, go to FINISH with a timeout result.
  - FINISH: done=1 for exactly this one cycle, then IDLE. Total: start accepted -> done takes at least TRIG_US*TICK_DIV + 3 cycles.
- Timeout result: echo_us <= {CNT_W{1'b1}}, timeout <= 1.
- Simultaneous events: if fall and the timeout limit land in the same cycle, fall wins and a valid result is recorded.
- Arithmetic:
  - The us counter saturates at TIMEOUT_US and never wraps.
  - For an echo width W cycles with W an exact multiple of TICK_DIV, echo_us = W/TICK_DIV.
  - Otherwise echo_us = floor(W/TICK_DIV).
- busy and done timing: busy is high from the cycle after start through the FINISH cycle, and low in the cycle after done.
- Reset mid-measurement: sonar_trig drops immediately (async); outputs return to reset values; no done pulse is produced.
- Echo glitches:
  - A rise/fall shorter than 1 clk may be missed; this is acceptable.
  - A second rise after fall in the same measurement is impossible, because the block has already left MEASURE.

Test Plan:
- TICK_DIV=4, TRIG_US=2: pulse start -> sonar_trig high exactly 8 cycles starting the cycle after start; busy=1 over the same span.
- Echo rises 40 cycles after trig falls and stays high 400 cycles -> done pulses once, echo_us=100, timeout=0; busy drops the cycle after done.
- TIMEOUT_US=50, echo held low -> done fires 200 cycles after entering WAIT_RISE (+1); echo_us=16'hFFFF, timeout=1.
- TIMEOUT_US=50, echo rises and stays high -> timeout result after 50 us in MEASURE. Echo held high across a new start -> no rise detected, so timeout again.
- start re-pulsed every 5 cycles during a measurement -> exactly one trigger and one done per accepted start.
- rst asserted mid-MEASURE with echo high -> sonar_trig, busy, done, echo_us all 0 asynchronously. After release, the next start with a 120-cycle echo gives echo_us=30.

Source files
------------

// File: rtl/sonar_echo_ranger.sv
// One ultrasonic ranger channel: fires the trigger pulse, then times the
// returning echo in microseconds with a timeout on both the wait and the width.
module sonar_echo_ranger #(
    parameter int TICK_DIV   = 50,
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 30000,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sonar_echo,
    output logic             sonar_trig,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] echo_us
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_US - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_US - 1);
    localparam logic [CNT_W-1:0] TMO_LIM   = CNT_W'(TIMEOUT_US);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        FINISH
    } state_t;

    state_t state, state_nx;

    logic echo_meta_p0, echo_sync_p1, echo_prev_p2;
    logic rise, fall;

    logic [TW-1:0]    tick_cnt;
    logic [CNT_W-1:0] us_cnt;
    logic             tick;
    logic             limit_hit;

    logic             res_load;
    logic             res_valid;
    logic [CNT_W-1:0] meas_val;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v >= TMO_LIM)
            return TMO_LIM;
        else
            return v + CNT_W'(1);
    endfunction

    // Echo synchroniser (p0, p1) and edge-detect history (p2)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_meta_p0 <= 1'b0;
            echo_sync_p1 <= 1'b0;
            echo_prev_p2 <= 1'b0;
        end else begin
            echo_meta_p0 <= sonar_echo;
            echo_sync_p1 <= echo_meta_p0;
            echo_prev_p2 <= echo_sync_p1;
        end
    end

    assign rise = echo_sync_p1 & ~echo_prev_p2;
    assign fall = ~echo_sync_p1 & echo_prev_p2;

    assign tick      = (tick_cnt == TICK_LAST);
    // The counter is about to reach the limit on this tick.
    assign limit_hit = tick && (us_cnt == TMO_LAST);

    // The fall cycle's own tick still belongs to the echo width.
    assign meas_val  = tick ? sat_inc(us_cnt) : us_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        res_load  = 1'b0;
        res_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nx = TRIG;
            end
            TRIG: begin
                if (tick && (us_cnt == TRIG_LAST))
                    state_nx = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (rise) begin
                    state_nx = MEASURE;
                end else if (limit_hit) begin
                    state_nx = FINISH;
                    res_load = 1'b1;
                end
            end
            MEASURE: begin
                if (fall) begin
                    state_nx  = FINISH;
                    res_load  = 1'b1;
                    res_valid = 1'b1;
                end else if (limit_hit) begin
                    state_nx = FINISH;
                    res_load = 1'b1;
                end
            end
            FINISH: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Prescaler and us counter restart on every state entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            us_cnt   <= '0;
        end else if ((state_nx != state) || (state == IDLE)) begin
            tick_cnt <= '0;
            us_cnt   <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
            us_cnt   <= sat_inc(us_cnt);
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_us <= '0;
            timeout <= 1'b0;
        end else if (res_load) begin
            if (res_valid) begin
                echo_us <= meas_val;
                timeout <= 1'b0;
            end else begin
                echo_us <= '1;
                timeout <= 1'b1;
            end
        end
    end

    assign sonar_trig = (state == TRIG);
    assign busy       = (state != IDLE);
    assign done       = (state == FINISH);

endmodule

// File: tb/tb_sonar_echo_ranger.sv
// Bench for sonar_echo_ranger: two instances (long and short timeout) share
// stimulus; a per-measurement timing model predicts every output each cycle.
module tb_sonar_echo_ranger;

    localparam int D   = 4;
    localparam int TU  = 2;
    localparam int TD  = TU * D;
    localparam int TO0 = 200;
    localparam int TO1 = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic echo = 1'b0;

    logic        trig_o[2];
    logic        busy_o[2];
    logic        done_o[2];
    logic        tmo_o[2];
    logic [15:0] us_o[2];

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    int          m_s = -2000;
    int          m_done[2] = '{-1000, -1000};
    logic [15:0] m_us_new[2] = '{16'd0, 16'd0};
    logic [15:0] m_us_prev[2] = '{16'd0, 16'd0};
    bit          m_to_new[2] = '{1'b0, 1'b0};
    bit          m_to_prev[2] = '{1'b0, 1'b0};

    sonar_echo_ranger #(.TICK_DIV(D), .TRIG_US(TU), .TIMEOUT_US(TO0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .start(start), .sonar_echo(echo),
        .sonar_trig(trig_o[0]), .busy(busy_o[0]), .done(done_o[0]),
        .timeout(tmo_o[0]), .echo_us(us_o[0])
    );

    sonar_echo_ranger #(.TICK_DIV(D), .TRIG_US(TU), .TIMEOUT_US(TO1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .start(start), .sonar_echo(echo),
        .sonar_trig(trig_o[1]), .busy(busy_o[1]), .done(done_o[1]),
        .timeout(tmo_o[1]), .echo_us(us_o[1])
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Measurement timeline from start cycle s. rise_off: cycles after the trigger
    // ends that the rise is seen (-1 = none); width: echo cycles (-1 = stays high).
    task automatic model(input int s, input int rise_off, input int width, input int to,
                         output int dn, output logic [15:0] us, output bit tm);
        int e, rd;
        e = s + 1 + TD;
        if (rise_off < 0 || rise_off >= to * D - 1) begin
            dn = e + to * D;
            us = 16'hFFFF;
            tm = 1'b1;
        end else begin
            rd = e + rise_off;
            if (width >= 0 && width <= to * D) begin
                dn = rd + width + 1;
                us = 16'(width / D);
                tm = 1'b0;
            end else begin
                dn = rd + 1 + to * D;
                us = 16'hFFFF;
                tm = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        bit          e_trig, e_busy, e_done, e_to;
        logic [15:0] e_us;
        for (int i = 0; i < 2; i++) begin
            e_trig = (cyc >= m_s + 1) && (cyc <= m_s + TD);
            e_busy = (cyc >= m_s + 1) && (cyc <= m_done[i]);
            e_done = (cyc == m_done[i]);
            e_us   = (cyc >= m_done[i]) ? m_us_new[i] : m_us_prev[i];
            e_to   = (cyc >= m_done[i]) ? m_to_new[i] : m_to_prev[i];
            chk($sformatf("trig%0d", i), trig_o[i], e_trig);
            chk($sformatf("busy%0d", i), busy_o[i], e_busy);
            chk($sformatf("done%0d", i), done_o[i], e_done);
            chk($sformatf("echo_us%0d", i), us_o[i], e_us);
            chk($sformatf("timeout%0d", i), tmo_o[i], e_to);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input int rise_off, input int width, input bit repulse, input int stop_after);
        int s, e, pin_on, last, lim;
        int dn[2];
        logic [15:0] us[2];
        bit tm[2];
        @(posedge clk);
        #1;
        s = cyc;
        e = s + 1 + TD;
        model(s, rise_off, width, TO0, dn[0], us[0], tm[0]);
        model(s, rise_off, width, TO1, dn[1], us[1], tm[1]);
        for (int i = 0; i < 2; i++) begin
            m_us_prev[i] = m_us_new[i];
            m_to_prev[i] = m_to_new[i];
            m_us_new[i]  = us[i];
            m_to_new[i]  = tm[i];
            m_done[i]    = dn[i];
        end
        m_s = s;
        pin_on = (rise_off >= 0) ? e + rise_off - 2 : -1;
        last = ((dn[0] > dn[1]) ? dn[0] : dn[1]) + 2;
        if (stop_after >= 0) last = s + stop_after;
        lim = (dn[0] < dn[1]) ? dn[0] : dn[1];
        for (int c = s; c <= last; c++) begin
            start = (c == s) || (repulse && c > s && c <= lim && ((c - s) % 5 == 0));
            if (pin_on >= 0 && c == pin_on) echo = 1'b1;
            if (pin_on >= 0 && width >= 0 && c == pin_on + width) echo = 1'b0;
            if (c < last) begin
                @(posedge clk);
                #1;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_trig%0d", tag, i), trig_o[i], 0);
            chk($sformatf("%s_busy%0d", tag, i), busy_o[i], 0);
            chk($sformatf("%s_done%0d", tag, i), done_o[i], 0);
            chk($sformatf("%s_us%0d", tag, i), us_o[i], 0);
            chk($sformatf("%s_to%0d", tag, i), tmo_o[i], 0);
        end
    endtask

    initial begin
        idle(3);
        rst = 1'b0;
        check_zero("reset");
        idle(2);

        // 400-cycle echo, rise 40 cycles after trigger ends
        run(40, 400, 1'b0, -1);
        chk("t2_lat0", m_done[0] - m_s, 450);
        chk("t2_lat1", m_done[1] - m_s, 250);
        chk("t2_us0", us_o[0], 100);
        chk("t2_to0", tmo_o[0], 0);
        chk("t2_us1", us_o[1], 16'hFFFF);
        chk("t2_to1", tmo_o[1], 1);
        idle(4);

        // No echo at all
        run(-1, -1, 1'b0, -1);
        chk("t3_lat1", m_done[1] - m_s, 209);
        chk("t3_lat0", m_done[0] - m_s, 809);
        chk("t3_us1", us_o[1], 16'hFFFF);
        chk("t3_to1", tmo_o[1], 1);

        // Echo rises and never falls
        run(15, -1, 1'b0, -1);
        chk("t4_lat1", m_done[1] - m_s, 225);
        chk("t4_to0", tmo_o[0], 1);

        // Echo already high at start: not a rise
        run(-1, -1, 1'b0, -1);
        chk("t5_lat1", m_done[1] - m_s, 209);
        chk("t5_us0", us_o[0], 16'hFFFF);
        chk("t5_to1", tmo_o[1], 1);
        echo = 1'b0;
        idle(6);

        // start re-pulsed every 5 cycles while busy
        run(10, 37, 1'b1, -1);
        chk("t6_lat", m_done[0] - m_s, 57);
        chk("t6_us0", us_o[0], 9);
        chk("t6_us1", us_o[1], 9);
        idle(3);

        // Fall on the same cycle as the limit: fall wins
        run(5, 200, 1'b0, -1);
        chk("t7_us1", us_o[1], 50);
        chk("t7_to1", tmo_o[1], 0);
        idle(3);

        // One cycle past the limit
        run(5, 201, 1'b0, -1);
        chk("t8_us0", us_o[0], 50);
        chk("t8_us1", us_o[1], 16'hFFFF);
        chk("t8_to1", tmo_o[1], 1);
        idle(3);

        // Reset while in MEASURE with echo high
        run(10, -1, 1'b0, 40);
        chk("t9_busy_pre", busy_o[0], 1);
        rst = 1'b1;
        m_s = -2000;
        for (int i = 0; i < 2; i++) begin
            m_done[i] = -1000;
            m_us_new[i] = 16'd0;
            m_us_prev[i] = 16'd0;
            m_to_new[i] = 1'b0;
            m_to_prev[i] = 1'b0;
        end
        #1;
        check_zero("async_rst");
        idle(3);
        rst = 1'b0;
        idle(4);
        echo = 1'b0;
        idle(4);

        run(20, 120, 1'b0, -1);
        chk("t10_lat", m_done[0] - m_s, 150);
        chk("t10_us0", us_o[0], 30);
        chk("t10_us1", us_o[1], 30);
        chk("t10_to0", tmo_o[0], 0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: got no end of stimulus, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
